// File: rtl/life_game_stepper_if.sv
// Cell-memory bus between the life stepper (master) and the memory/arbiter side (slave).
interface life_game_stepper_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [6:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output bus_req,
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  bus_gnt,
    input  mem_rdata
  );

  modport slave (
    input  bus_req,
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output bus_gnt,
    output mem_rdata
  );
endinterface

// File: rtl/life_game_stepper.sv
// Game of Life generation engine: reads the 64x64 toroidal grid row by row over the
// cell-memory bus and writes each next-generation row back in place.
//
// state  | meaning
// IDLE   | bus released, waiting for start
// REQ    | bus_req high, waiting for bus_gnt
// LOAD   | read rows 63 and 0 into prev/cur (and row0_save), 5 cycles
// RD     | read row r+1 into next, 3 cycles
// WR     | write the new row r, low word then high word
// DONE   | one-cycle done pulse, count the generation
module life_game_stepper #(
  parameter logic [8:0] BIRTH   = 9'b000001000,
  parameter logic [8:0] SURVIVE = 9'b000001100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                gen_count,
  life_game_stepper_if.master        bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state;
  logic [2:0]  phase;
  logic [5:0]  row;
  logic [5:0]  row_nxt;
  logic [63:0] prev_row;
  logic [63:0] cur_row;
  logic [63:0] next_row;
  logic [63:0] row0_save;
  logic [63:0] new_row;

  // Rotations line each cell up with its west (col-1) and east (col+1) neighbour.
  logic [63:0] prev_w, prev_e, cur_w, cur_e, next_w, next_e;

  assign prev_w = {prev_row[62:0], prev_row[63]};
  assign prev_e = {prev_row[0], prev_row[63:1]};
  assign cur_w  = {cur_row[62:0], cur_row[63]};
  assign cur_e  = {cur_row[0], cur_row[63:1]};
  assign next_w = {next_row[62:0], next_row[63]};
  assign next_e = {next_row[0], next_row[63:1]};

  assign row_nxt = row + 6'd1;

  function automatic logic [3:0] nbr_count(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + 4'(v[i]);
    end
    return sum;
  endfunction

  always_comb begin
    logic [3:0] n;
    new_row = '0;
    n       = 4'd0;
    for (int c = 0; c < 64; c++) begin
      n = nbr_count({prev_w[c], prev_row[c], prev_e[c],
                     cur_w[c], cur_e[c],
                     next_w[c], next_row[c], next_e[c]});
      new_row[c] = cur_row[c] ? SURVIVE[n] : BIRTH[n];
    end
  end

  assign busy        = (state == S_REQ) || (state == S_LOAD) ||
                       (state == S_RD)  || (state == S_WR);
  assign bus.bus_req = busy;
  assign done        = (state == S_DONE);

  // Address/data are only driven once the bus has been granted (LOAD/RD/WR).
  always_comb begin
    bus.mem_addr  = 7'd0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 32'd0;
    case (state)
      S_LOAD: begin
        case (phase)
          3'd0:    bus.mem_addr = 7'd126;
          3'd1:    bus.mem_addr = 7'd127;
          3'd2:    bus.mem_addr = 7'd0;
          3'd3:    bus.mem_addr = 7'd1;
          default: bus.mem_addr = 7'd0;
        endcase
      end
      S_RD: begin
        if (phase == 3'd0) begin
          bus.mem_addr = {row_nxt, 1'b0};
        end else if (phase == 3'd1) begin
          bus.mem_addr = {row_nxt, 1'b1};
        end
      end
      S_WR: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {row, phase[0]};
        bus.mem_wdata = phase[0] ? new_row[63:32] : new_row[31:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase     <= 3'd0;
      row       <= 6'd0;
      prev_row  <= '0;
      cur_row   <= '0;
      next_row  <= '0;
      row0_save <= '0;
      gen_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.bus_gnt) begin
            state <= S_LOAD;
            phase <= 3'd0;
          end
        end
        S_LOAD: begin
          phase <= phase + 3'd1;
          case (phase)
            3'd1: prev_row[31:0]  <= bus.mem_rdata;
            3'd2: prev_row[63:32] <= bus.mem_rdata;
            3'd3: begin
              cur_row[31:0]   <= bus.mem_rdata;
              row0_save[31:0] <= bus.mem_rdata;
            end
            3'd4: begin
              cur_row[63:32]   <= bus.mem_rdata;
              row0_save[63:32] <= bus.mem_rdata;
              row              <= 6'd0;
              phase            <= 3'd0;
              state            <= S_RD;
            end
            default: ;
          endcase
        end
        S_RD: begin
          phase <= phase + 3'd1;
          if (phase == 3'd1) begin
            next_row[31:0] <= bus.mem_rdata;
          end else if (phase == 3'd2) begin
            next_row[63:32] <= bus.mem_rdata;
            phase           <= 3'd0;
            state           <= S_WR;
          end
        end
        S_WR: begin
          if (phase == 3'd0) begin
            phase <= 3'd1;
          end else begin
            phase <= 3'd0;
            if (row == 6'd63) begin
              state <= S_DONE;
            end else begin
              prev_row <= cur_row;
              cur_row  <= next_row;
              row      <= row_nxt;
              // Row 0 has already been overwritten; the last row wraps onto the saved copy.
              if (row_nxt == 6'd63) begin
                next_row <= row0_save;
                state    <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_DONE: begin
          gen_count <= gen_count + 16'd1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_game_stepper.sv
// Scoreboard bench for life_game_stepper: directed grids with hand-computed next generations.
module tb_life_game_stepper;
  typedef struct packed {
    logic [4095:0] img;
    logic [15:0]   gen;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] gen_count;
  logic        gnt_en = 1'b1;

  life_game_stepper_if bus ();

  life_game_stepper dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  assign bus.bus_gnt = gnt_en;

  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_done = 0;
  int          idle_viol = 0;
  exp_t        sb_q[$];
  exp_t        e;
  logic [15:0] exp_gen = 16'd0;
  bit          owned = 1'b0;
  int          gnt_cyc = 0;
  int          we_count = 0;
  bit          pend_gen = 1'b0;
  logic [15:0] pend_val = 16'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: measures grant-to-done latency and write strobes, compares the grid on done.
  always @(negedge clk) begin
    if (!rst) begin
      owned    = 1'b0;
      pend_gen = 1'b0;
    end else begin
      if (pend_gen) begin
        chk("gen_count", 64'(gen_count), 64'(pend_val));
        pend_gen = 1'b0;
      end
      if (!owned && bus.bus_req && bus.bus_gnt) begin
        owned    = 1'b1;
        gnt_cyc  = cyc;
        we_count = 0;
      end
      if (bus.mem_we) we_count++;
      if (!bus.bus_req && (bus.mem_we || bus.mem_addr != 7'd0 || bus.mem_wdata != 32'd0))
        idle_viol++;
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done with gen_count=%0d, expected no done", gen_count);
        end else begin
          int bad;
          e = sb_q.pop_front();
          chk("latency", 64'(cyc - gnt_cyc), 64'd323);
          chk("write_strobes", 64'(we_count), 64'd128);
          chk("bus_req_at_done", 64'(bus.bus_req), 64'd0);
          bad = -1;
          for (int i = 127; i >= 0; i--)
            if (mem[i] !== e.img[i*32 +: 32]) bad = i;
          n_checks++;
          if (bad < 0) n_pass++;
          else $display("FAIL grid word %0d: got %h expected %h", bad, mem[bad], e.img[bad*32 +: 32]);
          pend_gen = 1'b1;
          pend_val = e.gen;
        end
        owned = 1'b0;
      end
    end
  end

  function automatic logic [4095:0] put(input logic [4095:0] img, input int w, input logic [31:0] v);
    logic [4095:0] r;
    r = img;
    r[w*32 +: 32] = v;
    return r;
  endfunction

  task automatic load_img(input logic [4095:0] img);
    for (int i = 0; i < 128; i++) mem[i] <= img[i*32 +: 32];
    @(negedge clk);
  endtask

  task automatic issue(input logic [4095:0] img);
    exp_t x;
    exp_gen = exp_gen + 16'd1;
    x.img = img;
    x.gen = exp_gen;
    sb_q.push_back(x);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (n_done == d0) begin
      n_checks++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", k);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [4095:0] zero, blink_a, blink_b, corner_a, corner_b, block;
    int bad;
    int d0;
    int k;
    zero     = '0;
    blink_a  = put(zero, 20, 32'h0000_00E0);
    blink_b  = put(put(put(zero, 18, 32'h40), 20, 32'h40), 22, 32'h40);
    corner_a = put(put(zero, 0, 32'h0000_0001), 1, 32'hC000_0000);
    corner_b = put(put(put(zero, 127, 32'h8000_0000), 1, 32'h8000_0000), 3, 32'h8000_0000);
    block    = put(put(zero, 40, 32'h18), 42, 32'h18);

    load_img(zero);
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_gen_count", 64'(gen_count), 64'd0);
    chk("rst_bus_req", 64'(bus.bus_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Blinker oscillates with period 2.
    load_img(blink_a);
    issue(blink_b);
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done();
    issue(blink_a);
    wait_done();

    // Horizontal triple straddling the column-63/0 seam turns vertical across row 63/0.
    load_img(corner_a);
    issue(corner_b);
    wait_done();

    load_img(block);
    repeat (3) begin
      issue(block);
      wait_done();
    end

    // Withheld grant: engine must request and wait without touching the bus.
    load_img(zero);
    gnt_en = 1'b0;
    issue(zero);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.bus_req || !busy || bus.mem_we || bus.mem_addr != 7'd0 || bus.mem_wdata != 32'd0) bad++;
    end
    chk("hs_hold_quiet", 64'(bad), 64'd0);
    @(posedge clk);
    #1 gnt_en = 1'b1;
    wait_done();

    // Start while busy, then start coincident with done: both ignored.
    d0 = n_done;
    issue(zero);
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_ignored", 64'(busy), 64'd0);
    repeat (400) @(negedge clk);
    chk("one_done", 64'(n_done - d0), 64'd1);
    chk("gen_after_busy_start", 64'(gen_count), 64'(exp_gen));

    issue(zero);
    wait_done();

    // Asynchronous reset during the write of row 30.
    issue(zero);
    k = 0;
    while (!(bus.mem_we && bus.mem_addr == 7'd60) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reached_row30_write", 64'(bus.mem_addr), 64'd60);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_gen_count", 64'(gen_count), 64'd0);
    chk("midrst_bus_req", 64'(bus.bus_req), 64'd0);
    chk("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("midrst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    sb_q.delete();
    exp_gen = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(zero);
    wait_done();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("idle_bus_quiet", 64'(idle_viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
